// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and writeback entry type for the register-file write arbiter
//
// Purpose: common constants and the FIFO payload type used by wb_fifo and rf_writeback_arbiter.
// Contents:
//   DATA_W      writeback data width (64)
//   REG_ADDR_W  register index width (5)
//   ZERO_REG    hard-wired zero register index; writes to it are discarded
//   wb_entry_t  {rd, data} payload carried through the requester FIFOs
//               (the destination field is named rd because 'reg' is a reserved word)

package rf_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback entries for one requester
//
// Purpose: buffers accepted writeback entries in arrival order until the arbiter pops them.
// Parameters:
//   DEPTH     number of entries; power of two, >= 2 (pointers wrap by natural overflow)
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-high reset; empties the FIFO
//   i_push    write i_data at the tail (ignored while full)
//   i_data    entry to write
//   i_pop     drop the head entry (ignored while empty)
//   o_head    current head entry (valid only when !o_empty)
//   o_full    count == DEPTH
//   o_empty   count == 0
//   o_count   number of stored entries, 0..DEPTH

module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  wb_entry_t                  i_data,
    input  logic                       i_pop,
    output wb_entry_t                  o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    // Full/empty come from the start-of-cycle count, so a full FIFO refuses a push
    // even on an edge where it also pops.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - round-robin arbiter sharing the register file write port
//
// Purpose: buffers ALU (Req0) and load (Req1) writebacks in per-requester FIFOs and drives
//          the register file write port from registered outputs, one write per cycle.
// Build option: RF_SCOREBOARD_EN enables the pending-write scoreboard (BusyA/BusyB);
//               without it the Resv*/RA/RB inputs are ignored and BusyA/BusyB are 0.
// Parameters:
//   DATA_W, ADDR_W  must match rf_pkg (entry type is fixed there)
//   FIFO_DEPTH      entries per requester FIFO; power of two, >= 2
// Ports:
//   Clk, Reset                  clock; asynchronous active-high reset
//   Wr0Valid/Ready/Reg/Data     Req0 (ALU) writeback handshake
//   Wr1Valid/Ready/Reg/Data     Req1 (load) writeback handshake
//   RegWr, RW, BusW             register file write port (registered)
//   Idle                        both FIFOs empty and no write on the port
//   ResvValid, ResvReg          destination reservation from issue
//   RA, RB                      hazard query indices
//   BusyA, BusyB                write pending on RA / RB

module rf_writeback_arbiter #(
    parameter int DATA_W     = rf_pkg::DATA_W,
    parameter int ADDR_W     = rf_pkg::REG_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wr0Valid,
    output logic              Wr0Ready,
    input  logic [ADDR_W-1:0] Wr0Reg,
    input  logic [DATA_W-1:0] Wr0Data,
    input  logic              Wr1Valid,
    output logic              Wr1Ready,
    input  logic [ADDR_W-1:0] Wr1Reg,
    input  logic [DATA_W-1:0] Wr1Data,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              Idle,
    input  logic              ResvValid,
    input  logic [ADDR_W-1:0] ResvReg,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              BusyA,
    output logic              BusyB
);

    import rf_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t          w_in0;
    wb_entry_t          w_in1;
    wb_entry_t          w_head0;
    wb_entry_t          w_head1;
    logic               w_full0;
    logic               w_full1;
    logic               w_empty0;
    logic               w_empty1;
    logic [CNT_W-1:0]   w_count0_unused;
    logic [CNT_W-1:0]   w_count1_unused;
    logic               w_push0;
    logic               w_push1;
    logic               w_gnt0;
    logic               w_gnt1;

    logic               r_reg_wr;
    logic [ADDR_W-1:0]  r_rw;
    logic [DATA_W-1:0]  r_busw;
    logic               r_last_gnt;   // 0 = Req0 granted last, 1 = Req1

    // Ready is forced low during reset so nothing is handshaken while the FIFOs are cleared.
    assign Wr0Ready = !w_full0 && !Reset;
    assign Wr1Ready = !w_full1 && !Reset;

    // Writes to the zero register complete the handshake but are never stored.
    assign w_push0 = Wr0Valid && Wr0Ready && (Wr0Reg != ZERO_REG);
    assign w_push1 = Wr1Valid && Wr1Ready && (Wr1Reg != ZERO_REG);

    assign w_in0.rd   = Wr0Reg;
    assign w_in0.data = Wr0Data;
    assign w_in1.rd   = Wr1Reg;
    assign w_in1.data = Wr1Data;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push0),
        .i_data  (w_in0),
        .i_pop   (w_gnt0),
        .o_head  (w_head0),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_count (w_count0_unused)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push1),
        .i_data  (w_in1),
        .i_pop   (w_gnt1),
        .o_head  (w_head1),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_count (w_count1_unused)
    );

    // Req1 wins when it is the only one waiting, or on a tie when Req0 went last.
    assign w_gnt1 = !w_empty1 && (w_empty0 || !r_last_gnt);
    assign w_gnt0 = !w_empty0 && !w_gnt1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_reg_wr   <= 1'b0;
            r_rw       <= '0;
            r_busw     <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_reg_wr <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                r_rw       <= w_head0.rd;
                r_busw     <= w_head0.data;
                r_last_gnt <= 1'b0;
            end else if (w_gnt1) begin
                r_rw       <= w_head1.rd;
                r_busw     <= w_head1.data;
                r_last_gnt <= 1'b1;
            end
        end
    end

    assign RegWr = r_reg_wr;
    assign RW    = r_rw;
    assign BusW  = r_busw;
    assign Idle  = w_empty0 && w_empty1 && !r_reg_wr;

`ifdef RF_SCOREBOARD_EN
    localparam int NREG = (1 << ADDR_W) - 1;   // every register except the zero register

    logic [NREG-1:0] r_pend;
    logic [NREG:0]   w_pend_ext;

    // A reservation landing on the same edge as the commit of that register wins,
    // so a re-issued destination stays busy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ResvValid && (ResvReg == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (r_reg_wr && (r_rw == ADDR_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Top bit stands for the zero register and is never pending.
    assign w_pend_ext = {1'b0, r_pend};
    assign BusyA      = w_pend_ext[RA];
    assign BusyB      = w_pend_ext[RB];
`else
    logic w_sb_unused;

    assign w_sb_unused = ^{ResvValid, ResvReg, RA, RB};
    assign BusyA       = 1'b0;
    assign BusyB       = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter

module tb_rf_writeback_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Wr0Valid, Wr1Valid;
    logic        Wr0Ready, Wr1Ready;
    logic [4:0]  Wr0Reg, Wr1Reg;
    logic [63:0] Wr0Data, Wr1Data;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        Idle;
    logic        ResvValid;
    logic [4:0]  ResvReg, RA, RB;
    logic        BusyA, BusyB;
    logic [63:0] BusA, BusB;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    rf_writeback_arbiter #(.DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Wr0Valid (Wr0Valid),
        .Wr0Ready (Wr0Ready),
        .Wr0Reg   (Wr0Reg),
        .Wr0Data  (Wr0Data),
        .Wr1Valid (Wr1Valid),
        .Wr1Ready (Wr1Ready),
        .Wr1Reg   (Wr1Reg),
        .Wr1Data  (Wr1Data),
        .RegWr    (RegWr),
        .RW       (RW),
        .BusW     (BusW),
        .Idle     (Idle),
        .ResvValid(ResvValid),
        .ResvReg  (ResvReg),
        .RA       (RA),
        .RB       (RB),
        .BusyA    (BusyA),
        .BusyB    (BusyB)
    );

    // Register file model: commits on the negedge, X31 reads as zero.
    logic [63:0] rf_mem [32];
    initial for (int i = 0; i < 32; i++) rf_mem[i] = 64'd0;
    always @(negedge Clk) if (RegWr === 1'b1 && RW != 5'd31) rf_mem[RW] <= BusW;
    assign BusA = (RA == 5'd31) ? 64'd0 : rf_mem[RA];
    assign BusB = (RB == 5'd31) ? 64'd0 : rf_mem[RB];

    typedef struct packed {
        logic [4:0]  rw;
        logic [63:0] d;
    } cm_t;
    cm_t commits[$];
    always @(negedge Clk) if (RegWr === 1'b1) commits.push_back({RW, BusW});

    typedef struct {
        logic        v0;
        logic [4:0]  r0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [63:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        wr;
        logic [4:0]  rw;
        logic [63:0] busw;
        logic        idle;
    } vec_t;

    function automatic vec_t mk(logic v0, logic [4:0] r0, logic [63:0] d0,
                                logic v1, logic [4:0] r1, logic [63:0] d1,
                                logic wr, logic [4:0] rw, logic [63:0] busw, logic idle);
        vec_t v;
        v.v0 = v0; v.r0 = r0; v.d0 = d0;
        v.v1 = v1; v.r1 = r1; v.d1 = d1;
        v.rdy0 = 1'b1; v.rdy1 = 1'b1;
        v.wr = wr; v.rw = rw; v.busw = busw; v.idle = idle;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Wr0Valid = 0; Wr0Reg = 0; Wr0Data = 0;
        Wr1Valid = 0; Wr1Reg = 0; Wr1Data = 0;
        ResvValid = 0; ResvReg = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        step();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (Idle !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(name, Idle, 1);
    endtask

    vec_t vecs[9];
    cm_t  exp0[$], exp1[$];

    initial begin
        int c0, c1, seq0, seq1;
        bit last, p0, p1, g0, g1;
        int k0, k1;

        idle_inputs();
        RA = 0; RB = 0;
        Reset = 1;
        #2;
        chk("rst_regwr", RegWr, 0);
        chk("rst_rw", RW, 0);
        chk("rst_busw", BusW, 0);
        chk("rst_idle", Idle, 1);
        chk("rst_rdy0", Wr0Ready, 0);
        chk("rst_rdy1", Wr1Ready, 0);
        chk("rst_busya", BusyA, 0);
        #10 Reset = 0;
        step();

        // ---- table-driven single-cycle vectors ----
        vecs[0] = mk(1, 5'd5, 64'hABCD, 0, 0, 0,             0, 5'd0, 64'h0,    0);
        vecs[1] = mk(0, 0, 0,           0, 0, 0,             1, 5'd5, 64'hABCD, 0);
        vecs[2] = mk(0, 0, 0,           0, 0, 0,             0, 5'd5, 64'hABCD, 1);
        vecs[3] = mk(0, 0, 0,           1, 5'd31, 64'h12345678, 0, 5'd5, 64'hABCD, 1);
        vecs[4] = mk(0, 0, 0,           0, 0, 0,             0, 5'd5, 64'hABCD, 1);
        vecs[5] = mk(1, 5'd7, 64'h70,   1, 5'd8, 64'h80,     0, 5'd5, 64'hABCD, 0);
        vecs[6] = mk(0, 0, 0,           0, 0, 0,             1, 5'd8, 64'h80,   0);
        vecs[7] = mk(0, 0, 0,           0, 0, 0,             1, 5'd7, 64'h70,   0);
        vecs[8] = mk(0, 0, 0,           0, 0, 0,             0, 5'd7, 64'h70,   1);

        for (int i = 0; i < 9; i++) begin
            Wr0Valid = vecs[i].v0; Wr0Reg = vecs[i].r0; Wr0Data = vecs[i].d0;
            Wr1Valid = vecs[i].v1; Wr1Reg = vecs[i].r1; Wr1Data = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_rdy0", i), Wr0Ready, vecs[i].rdy0);
            chk($sformatf("v%0d_rdy1", i), Wr1Ready, vecs[i].rdy1);
            step();
            idle_inputs();
            chk($sformatf("v%0d_regwr", i), RegWr, vecs[i].wr);
            chk($sformatf("v%0d_rw", i), RW, vecs[i].rw);
            chk($sformatf("v%0d_busw", i), BusW, vecs[i].busw);
            chk($sformatf("v%0d_idle", i), Idle, vecs[i].idle);
        end

        RA = 5'd5; RB = 5'd31; #1;
        chk("read_x5", BusA, 64'hABCD);
        chk("read_x31", BusB, 64'h0);
        RA = 5'd7; RB = 5'd8; #1;
        chk("read_x7", BusA, 64'h70);
        chk("read_x8", BusB, 64'h80);

        // ---- reset mid-burst ----
        Wr0Valid = 1; Wr0Reg = 5'd3; Wr0Data = 64'hDEAD;
        Wr1Valid = 1; Wr1Reg = 5'd20; Wr1Data = 64'hBEEF;
        step();
        step();
        chk("burst_inflight", RegWr, 1);
        #3 Reset = 1;
        #1;
        chk("mid_rst_regwr", RegWr, 0);
        chk("mid_rst_rw", RW, 0);
        chk("mid_rst_busw", BusW, 0);
        chk("mid_rst_idle", Idle, 1);
        chk("mid_rst_rdy0", Wr0Ready, 0);
        chk("mid_rst_rdy1", Wr1Ready, 0);
        idle_inputs();
        #2 Reset = 0;
        step();
        chk("post_rst_regwr", RegWr, 0);
        chk("post_rst_idle", Idle, 1);
        chk("post_rst_rdy0", Wr0Ready, 1);
        chk("post_rst_rdy1", Wr1Ready, 1);

        // ---- both push every cycle: strict alternation starting with Req0 ----
        commits.delete();
        for (int i = 0; i < 4; i++) begin
            Wr0Valid = 1; Wr0Reg = 5'(1 + i);  Wr0Data = 64'h100 + 64'(i);
            Wr1Valid = 1; Wr1Reg = 5'(11 + i); Wr1Data = 64'h200 + 64'(i);
            #1;
            chk($sformatf("alt_rdy0_%0d", i), Wr0Ready, 1);
            chk($sformatf("alt_rdy1_%0d", i), Wr1Ready, 1);
            step();
        end
        idle_inputs();
        wait_idle("alt_idle");
        chk("alt_count", commits.size(), 8);
        for (int k = 0; k < 8 && k < commits.size(); k++) begin
            cm_t e;
            e.rw = (k % 2 == 0) ? 5'(1 + k / 2) : 5'(11 + k / 2);
            e.d  = (k % 2 == 0) ? 64'h100 + 64'(k / 2) : 64'h200 + 64'(k / 2);
            chk($sformatf("alt_commit_%0d", k), commits[k], e);
        end

        // ---- saturation: FIFOs fill, Ready drops, all accepted writes drain in order ----
        apply_reset();
        commits.delete();
        c0 = 0; c1 = 0; seq0 = 0; seq1 = 0; last = 1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            Wr0Valid = 1; Wr0Reg = 5'(1 + seq0 % 8);  Wr0Data = 64'hA000 + 64'(seq0);
            Wr1Valid = 1; Wr1Reg = 5'(16 + seq1 % 8); Wr1Data = 64'hB000 + 64'(seq1);
            p0 = (c0 < 4); p1 = (c1 < 4);
            #1;
            chk($sformatf("sat_rdy0_%0d", cyc), Wr0Ready, p0);
            chk($sformatf("sat_rdy1_%0d", cyc), Wr1Ready, p1);
            g1 = (c1 > 0) && ((c0 == 0) || !last);
            g0 = (c0 > 0) && !g1;
            if (p0) begin exp0.push_back({Wr0Reg, Wr0Data}); seq0++; end
            if (p1) begin exp1.push_back({Wr1Reg, Wr1Data}); seq1++; end
            c0 = c0 + int'(p0) - int'(g0);
            c1 = c1 + int'(p1) - int'(g1);
            if (g0) last = 0;
            if (g1) last = 1;
            step();
        end
        idle_inputs();
        wait_idle("sat_idle");
        chk("sat_count", commits.size(), exp0.size() + exp1.size());
        k0 = 0; k1 = 0;
        foreach (commits[k]) begin
            if (commits[k].d[15:12] == 4'hA) begin
                if (k0 < exp0.size()) chk($sformatf("sat_req0_%0d", k0), commits[k], exp0[k0]);
                k0++;
            end else begin
                if (k1 < exp1.size()) chk($sformatf("sat_req1_%0d", k1), commits[k], exp1[k1]);
                k1++;
            end
        end
        chk("sat_req0_total", k0, exp0.size());
        chk("sat_req1_total", k1, exp1.size());

        // ---- scoreboard ----
        apply_reset();
        RA = 5'd10; RB = 5'd31;
        ResvValid = 1; ResvReg = 5'd10;
        step();
        ResvValid = 0;
`ifdef RF_SCOREBOARD_EN
        chk("sb_resv_busya", BusyA, 1);
        chk("sb_x31_busyb", BusyB, 0);
        Wr0Valid = 1; Wr0Reg = 5'd10; Wr0Data = 64'h55;
        step();
        idle_inputs();
        chk("sb_queued_busya", BusyA, 1);
        step();
        chk("sb_commit_regwr", RegWr, 1);
        chk("sb_commit_busya", BusyA, 1);
        step();
        chk("sb_cleared_busya", BusyA, 0);
        chk("sb_read_x10", BusA, 64'h55);
        Wr0Valid = 1; Wr0Reg = 5'd10; Wr0Data = 64'h66;
        step();
        idle_inputs();
        step();
        chk("sb_commit2_regwr", RegWr, 1);
        ResvValid = 1; ResvReg = 5'd10;
        step();
        ResvValid = 0;
        chk("sb_set_wins_busya", BusyA, 1);
`else
        RB = 5'd10; #1;
        chk("nosb_busya", BusyA, 0);
        chk("nosb_busyb", BusyB, 0);
        Wr0Valid = 1; Wr0Reg = 5'd10; Wr0Data = 64'h55;
        step();
        idle_inputs();
        step();
        step();
        chk("nosb_read_x10", BusA, 64'h55);
        chk("nosb_busya_after", BusyA, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
